// File: rtl/otter_fetch_queue.sv
// Instruction-fetch front end for the pipelined OTTER CPU: owns the fetch PC,
// issues one-cycle memory reads and queues {ir, pc} pairs for decode.
module otter_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             redirect_i,
    input  logic [31:0]                      redirect_pc_i,
    output logic                             imem_rd_o,
    output logic [31:0]                      imem_addr_o,
    input  logic [31:0]                      imem_data_i,
    output logic                             de_valid_o,
    output logic [31:0]                      de_ir_o,
    output logic [31:0]                      de_pc_o,
    input  logic                             de_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]       fq_count_o
);

    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   ir_q [DEPTH];
    logic [31:0]   pc_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;

    logic          credit_ok;
    logic          issue;
    logic          push;
    logic          pop;

    // Credit check counts queued plus in-flight work; a same-cycle pop is not credited.
    always_comb begin
        credit_ok = ({1'b0, count_q} + (CW+1)'(inflight_q)) < (CW+1)'(DEPTH);
        issue     = !reset_i && (redirect_i || credit_ok);
        push      = inflight_q && !redirect_i && !reset_i;

        imem_rd_o = issue;
        if (reset_i) begin
            imem_addr_o = RESET_PC;
        end else if (redirect_i) begin
            imem_addr_o = redirect_pc_i;
        end else begin
            imem_addr_o = fetch_pc_q;
        end

        de_valid_o = !reset_i && !redirect_i && (count_q != '0);
        de_ir_o    = NOP;
        de_pc_o    = 32'h0000_0000;
        if (de_valid_o) begin
            de_ir_o = ir_q[rd_ptr_q];
            de_pc_o = pc_q[rd_ptr_q];
        end
        pop        = de_valid_o && de_ready_i;
        fq_count_o = reset_i ? '0 : count_q;
    end

    // Next-state for the non-reset path; a redirect flushes everything queued.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;

        if (redirect_i) begin
            inflight_d    = 1'b1;
            inflight_pc_d = redirect_pc_i;
            fetch_pc_d    = redirect_pc_i + 32'd4;
            count_d       = '0;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
        end else begin
            if (issue) begin
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + 32'd4;
            end else begin
                inflight_d    = 1'b0;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Queue storage needs no reset; count gates every read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            ir_q[wr_ptr_q] <= imem_data_i;
            pc_q[wr_ptr_q] <= inflight_pc_q;
        end
    end

endmodule

// File: tb/tb_otter_fetch_queue.sv
// Directed bench for otter_fetch_queue: a negedge monitor scores every decode
// handshake against a queue of expected PCs; timing points are checked directly.
module tb_otter_fetch_queue;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, redirect, imem_rd, de_valid, de_ready;
    logic [31:0] redirect_pc, imem_addr, imem_data, de_ir, de_pc;
    logic [2:0]  fq_count;

    logic        w_reset, w_redirect, w_imem_rd, w_de_valid, w_de_ready;
    logic [31:0] w_redirect_pc, w_imem_addr, w_imem_data, w_de_ir, w_de_pc;
    logic [2:0]  w_fq_count;

    otter_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
        .clk_i(clk), .reset_i(reset), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .imem_rd_o(imem_rd), .imem_addr_o(imem_addr), .imem_data_i(imem_data),
        .de_valid_o(de_valid), .de_ir_o(de_ir), .de_pc_o(de_pc), .de_ready_i(de_ready),
        .fq_count_o(fq_count)
    );

    otter_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk_i(clk), .reset_i(w_reset), .redirect_i(w_redirect), .redirect_pc_i(w_redirect_pc),
        .imem_rd_o(w_imem_rd), .imem_addr_o(w_imem_addr), .imem_data_i(w_imem_data),
        .de_valid_o(w_de_valid), .de_ir_o(w_de_ir), .de_pc_o(w_de_pc), .de_ready_i(w_de_ready),
        .fq_count_o(w_fq_count)
    );

    // Memory models: data = addr ^ mem_xor, one cycle after the read.
    logic [31:0] mem_xor;
    always @(posedge clk) imem_data   <= imem_rd   ? (imem_addr ^ mem_xor) : 32'hBAD0_BAD0;
    always @(posedge clk) w_imem_data <= w_imem_rd ? w_imem_addr           : 32'hBAD0_BAD0;

    int          tests = 0;
    int          fails = 0;
    int          pop_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] issued_q[$];
    logic [31:0] mon_e;

    // Monitor: log every fetch request, score every accepted instruction.
    always @(negedge clk) begin
        if (imem_rd) issued_q.push_back(imem_addr);
        if (de_valid && de_ready) begin
            pop_cnt++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL pop_unexpected actual pc=%h ir=%h required no pop", de_pc, de_ir);
            end else begin
                mon_e = exp_q.pop_front();
                if (de_pc !== mon_e || de_ir !== (mon_e ^ mem_xor)) begin
                    fails++;
                    $display("FAIL pop_entry actual pc=%h ir=%h required pc=%h ir=%h",
                             de_pc, de_ir, mon_e, mon_e ^ mem_xor);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits;
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; de_ready = 1'b1; mem_xor = '0;
        w_reset = 1'b1; w_redirect = 1'b0; w_redirect_pc = '0; w_de_ready = 1'b1;

        // Reset cycle outputs
        tick(); #2;
        chk("rst_rd",    32'(imem_rd),  32'd0);
        chk("rst_valid", 32'(de_valid), 32'd0);
        chk("rst_ir",    de_ir,         32'h0000_0013);
        chk("rst_pc",    de_pc,         32'd0);
        chk("rst_count", 32'(fq_count), 32'd0);
        chk("rst_addr",  imem_addr,     32'd0);

        // Cold start
        push_seq(32'h0, 20);
        pop_cnt = 0;
        for (int c = 1; c <= 10; c++) begin
            tick(); reset = 1'b0; #2;
            chk("cold_addr",  imem_addr,     32'(4 * (c - 1)));
            chk("cold_rd",    32'(imem_rd),  32'd1);
            chk("cold_valid", 32'(de_valid), (c >= 3) ? 32'd1 : 32'd0);
        end

        // Backpressure: reset, then hold decode stalled
        tick();
        chk("cold_pops", 32'(pop_cnt), 32'd8);
        reset = 1'b1; de_ready = 1'b0; mem_xor = 32'hDEAD_0000; exp_q.delete();
        #2; issued_q.delete();
        for (int c = 1; c <= 8; c++) begin
            tick(); reset = 1'b0; #2;
            if (c == 8) begin
                chk("bp_count", 32'(fq_count), 32'd4);
                chk("bp_rd",    32'(imem_rd),  32'd0);
            end
        end
        chk("bp_nreq", 32'(issued_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("bp_req_addr", issued_q[i], 32'(4 * i));
        push_seq(32'h0, 20);
        pop_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            tick(); de_ready = 1'b1; #2;
            chk("bp_nogap", 32'(de_valid), 32'd1);
        end

        // Redirect mid-stream
        tick();
        chk("bp_pops", 32'(pop_cnt), 32'd10);
        redirect = 1'b1; redirect_pc = 32'h100; exp_q.delete(); push_seq(32'h100, 10);
        #2;
        chk("rd_addr",  imem_addr,     32'h100);
        chk("rd_rd",    32'(imem_rd),  32'd1);
        chk("rd_v0",    32'(de_valid), 32'd0);
        tick(); redirect = 1'b0; #2;
        chk("rd_v1",    32'(de_valid), 32'd0);
        tick(); #2;
        chk("rd_v2",    32'(de_valid), 32'd1);
        chk("rd_pc2",   de_pc,         32'h100);
        tick(); #2;
        chk("rd_pc3",   de_pc,         32'h104);

        // Redirect while full and stalled
        for (int c = 0; c < 6; c++) begin
            tick(); de_ready = 1'b0; #2;
        end
        chk("full_count", 32'(fq_count), 32'd4);
        tick(); redirect = 1'b1; redirect_pc = 32'h200; exp_q.delete(); push_seq(32'h200, 10);
        #2;
        chk("full_v0",   32'(de_valid), 32'd0);
        chk("full_addr", imem_addr,     32'h200);
        tick(); redirect = 1'b0; #2;
        chk("full_c1",   32'(fq_count), 32'd0);
        tick(); #2;
        chk("full_c2",   32'(fq_count), 32'd1);
        chk("full_pc2",  de_pc,         32'h200);
        for (int c = 0; c < 4; c++) begin
            tick(); de_ready = 1'b1; #2;
        end

        // Reset together with redirect, three queued and one in flight
        tick(); de_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h300; exp_q.delete();
        for (int c = 1; c <= 4; c++) begin
            tick(); redirect = 1'b0; #2;
        end
        chk("rr_count3", 32'(fq_count), 32'd3);
        reset = 1'b1; redirect = 1'b1; redirect_pc = 32'h400; issued_q.delete(); #1;
        chk("rr_rd",     32'(imem_rd),  32'd0);
        chk("rr_valid",  32'(de_valid), 32'd0);
        push_seq(32'h0, 10);
        tick(); reset = 1'b0; redirect = 1'b0; de_ready = 1'b1; #2;
        chk("rr_next_valid", 32'(de_valid), 32'd0);
        chk("rr_next_count", 32'(fq_count), 32'd0);
        chk("rr_next_addr",  imem_addr,     32'd0);
        chk("rr_next_rd",    32'(imem_rd),  32'd1);
        for (int c = 0; c < 5; c++) tick();
        hits = 0;
        foreach (issued_q[i]) if (issued_q[i] == 32'h400) hits++;
        chk("rr_no_target", 32'(hits), 32'd0);
        chk("rr_first_req", issued_q[0], 32'd0);

        // Wrap instance
        for (int c = 1; c <= 6; c++) begin
            tick(); w_reset = 1'b0; #2;
            if (c <= 4) chk("wrap_addr", w_imem_addr, 32'hFFFF_FFF8 + 32'(4 * (c - 1)));
            if (c >= 3) begin
                chk("wrap_valid", 32'(w_de_valid), 32'd1);
                chk("wrap_pc",    w_de_pc, 32'hFFFF_FFF8 + 32'(4 * (c - 3)));
                chk("wrap_ir",    w_de_ir, 32'hFFFF_FFF8 + 32'(4 * (c - 3)));
            end
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
